// File: rtl/phmm_job_scheduler_if.sv
// Job-scheduler bus: base loading, job commit, array fetch/clear, and result handshake.
interface phmm_job_scheduler_if #(
  parameter int MAX_LEN = 64,
  parameter int BASE_W  = 2,
  parameter int ID_W    = 4
);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic              ld_valid;
  logic              ld_sel;
  logic [IDX_W-1:0]  ld_addr;
  logic [BASE_W-1:0] ld_data;
  logic              job_valid;
  logic [LEN_W-1:0]  job_len;
  logic [ID_W-1:0]   job_id;
  logic              job_ready;

  logic              arr_reset;
  logic [LEN_W-1:0]  arr_len;
  logic              arr_x_req;
  logic [IDX_W-1:0]  arr_x_idx;
  logic              arr_y_req;
  logic [IDX_W-1:0]  arr_y_idx;
  logic [BASE_W-1:0] arr_x_base;
  logic [BASE_W-1:0] arr_y_base;
  logic              arr_base_vld;
  logic              arr_complete;
  logic [63:0]       arr_final;

  logic              res_valid;
  logic              res_ready;
  logic [ID_W-1:0]   res_id;
  logic [63:0]       res_val;
  logic              res_err;

  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, job_valid, job_len, job_id,
    input  arr_x_req, arr_x_idx, arr_y_req, arr_y_idx, arr_complete, arr_final,
    input  res_ready,
    output job_ready, arr_reset, arr_len, arr_x_base, arr_y_base, arr_base_vld,
    output res_valid, res_id, res_val, res_err
  );

  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, job_valid, job_len, job_id,
    output arr_x_req, arr_x_idx, arr_y_req, arr_y_idx, arr_complete, arr_final,
    output res_ready,
    input  job_ready, arr_reset, arr_len, arr_x_base, arr_y_base, arr_base_vld,
    input  res_valid, res_id, res_val, res_err
  );
endinterface

// File: rtl/phmm_job_scheduler.sv
// Pair-HMM job sequencer: ping-pong base banks, array clear/run control with
// watchdog, base fetch service, and id-tagged result output.
module phmm_job_scheduler #(
  parameter int MAX_LEN = 64,
  parameter int BASE_W  = 2,
  parameter int ID_W    = 4,
  parameter int WDOG    = 65535
) (
  input logic clock,
  input logic reset,
  phmm_job_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int WD_W  = $clog2(WDOG + 1);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [WD_W-1:0]  WDOG_LAST = WD_W'(WDOG - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic              wr_bank, rd_bank;
  logic [1:0]        full;
  logic [LEN_W-1:0]  len_q [2];
  logic [ID_W-1:0]   id_q  [2];
  logic [BASE_W-1:0] x_mem [2][MAX_LEN];
  logic [BASE_W-1:0] y_mem [2][MAX_LEN];
  logic              clr_cnt;
  logic [WD_W-1:0]   wdog;
  logic [63:0]       cur_val;
  logic              cur_err;

  logic commit, ld_acc, publish, run, len_bad;

  assign commit  = bus.job_valid && bus.job_ready;
  assign ld_acc  = bus.ld_valid && bus.job_ready && !reset;
  assign publish = (state == S_DONE) && (!bus.res_valid || bus.res_ready);
  assign run     = (state == S_RUN);
  assign len_bad = (len_q[rd_bank] == '0) || (len_q[rd_bank] > MAX_LEN_L);

  assign bus.job_ready = !full[wr_bank];
  assign bus.arr_reset = reset || (state == S_CLEAR);

  // Base storage has no reset: bank contents only matter once the bank is marked full.
  always_ff @(posedge clock) begin
    if (ld_acc) begin
      if (bus.ld_sel) y_mem[wr_bank][bus.ld_addr] <= bus.ld_data;
      else            x_mem[wr_bank][bus.ld_addr] <= bus.ld_data;
    end
  end

  // Commit and release touch different banks whenever both fire, so neither masks the other.
  always_ff @(posedge clock) begin
    if (reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      len_q   <= '{default: '0};
      id_q    <= '{default: '0};
    end else begin
      if (commit) begin
        full[wr_bank]  <= 1'b1;
        len_q[wr_bank] <= bus.job_len;
        id_q[wr_bank]  <= bus.job_id;
        wr_bank        <= ~wr_bank;
      end
      if (publish) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.arr_base_vld <= 1'b0;
      bus.arr_x_base   <= '0;
      bus.arr_y_base   <= '0;
    end else begin
      bus.arr_base_vld <= run && (bus.arr_x_req || bus.arr_y_req);
      bus.arr_x_base   <= (run && bus.arr_x_req && (LEN_W'(bus.arr_x_idx) < bus.arr_len))
                          ? x_mem[rd_bank][bus.arr_x_idx] : '0;
      bus.arr_y_base   <= (run && bus.arr_y_req && (LEN_W'(bus.arr_y_idx) < bus.arr_len))
                          ? y_mem[rd_bank][bus.arr_y_idx] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      clr_cnt       <= 1'b0;
      wdog          <= '0;
      cur_val       <= '0;
      cur_err       <= 1'b0;
      bus.arr_len   <= '0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= '0;
      bus.res_val   <= '0;
      bus.res_err   <= 1'b0;
    end else begin
      if (bus.res_valid && bus.res_ready) bus.res_valid <= 1'b0;
      case (state)
        S_IDLE: if (full[rd_bank]) begin
          if (len_bad) begin
            cur_err <= 1'b1;
            cur_val <= '0;
            state   <= S_DONE;
          end else begin
            bus.arr_len <= len_q[rd_bank];
            clr_cnt     <= 1'b0;
            state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          clr_cnt <= 1'b1;
          if (clr_cnt) begin
            wdog  <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.arr_complete) begin
            cur_val <= bus.arr_final;
            cur_err <= 1'b0;
            state   <= S_DONE;
          end else if (wdog == WDOG_LAST) begin
            cur_val <= '0;
            cur_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_DONE: if (publish) begin
          bus.res_valid <= 1'b1;
          bus.res_id    <= id_q[rd_bank];
          bus.res_val   <= cur_val;
          bus.res_err   <= cur_err;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_phmm_job_scheduler.sv
// Directed + randomized bench for phmm_job_scheduler against a job-level model.
module tb_phmm_job_scheduler;
  localparam int MAX_LEN = 64;
  localparam int WDOG    = 16;

  typedef struct packed {
    logic [3:0]       id;
    logic [6:0]       len;
    logic [63:0][1:0] x;
    logic [63:0][1:0] y;
  } job_t;

  logic clock, reset;
  int   n_cmp = 0;
  int   n_err = 0;
  job_t ja, jb;

  phmm_job_scheduler_if #(.MAX_LEN(MAX_LEN), .BASE_W(2), .ID_W(4)) bus ();

  phmm_job_scheduler #(.MAX_LEN(MAX_LEN), .BASE_W(2), .ID_W(4), .WDOG(WDOG)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic make_job(output job_t j, input int id, input int len);
    j = '0;
    j.id  = id[3:0];
    j.len = len[6:0];
    for (int i = 0; i < MAX_LEN; i++) begin
      j.x[i] = 2'($urandom_range(0, 3));
      j.y[i] = 2'($urandom_range(0, 3));
    end
  endtask

  // Final load overlaps the commit, so it must land in the bank being committed.
  task automatic load_commit(input job_t j);
    int n;
    n = (int'(j.len) > MAX_LEN) ? 0 : int'(j.len);
    chk("job_ready_before_load", bus.job_ready, 1'b1);
    for (int i = 0; i < n; i++) begin
      bus.ld_valid = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = 6'(i); bus.ld_data = j.x[i];
      tick();
      bus.ld_sel = 1'b1; bus.ld_data = j.y[i];
      if (i == n - 1) begin
        bus.job_valid = 1'b1; bus.job_len = j.len; bus.job_id = j.id;
      end
      tick();
    end
    if (n == 0) begin
      bus.job_valid = 1'b1; bus.job_len = j.len; bus.job_id = j.id;
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_clear(input job_t j);
    int c;
    c = 0;
    while (!bus.arr_reset && c < 40) begin tick(); c++; end
    chk("clear_start", bus.arr_reset, 1'b1);
    c = 0;
    while (bus.arr_reset && c < 10) begin tick(); c++; end
    chk("clear_cycles", c, 2);
    chk("arr_len", bus.arr_len, j.len);
  endtask

  task automatic fetch(input job_t j, input bit xr, input bit yr, input int xi, input int yi);
    bus.arr_x_req = xr; bus.arr_x_idx = 6'(xi);
    bus.arr_y_req = yr; bus.arr_y_idx = 6'(yi);
    tick();
    bus.arr_x_req = 1'b0; bus.arr_y_req = 1'b0;
    chk("base_vld", bus.arr_base_vld, 1'b1);
    if (xr) chk("x_base", bus.arr_x_base, (xi < int'(j.len)) ? j.x[xi] : 2'b00);
    if (yr) chk("y_base", bus.arr_y_base, (yi < int'(j.len)) ? j.y[yi] : 2'b00);
  endtask

  task automatic complete(input logic [63:0] fin);
    bus.arr_complete = 1'b1; bus.arr_final = fin;
    tick();
    bus.arr_complete = 1'b0;
  endtask

  task automatic get_result(input logic [3:0] id, input logic [63:0] val, input bit err, input bit ack);
    int c;
    c = 0;
    while (!bus.res_valid && c < 60) begin tick(); c++; end
    chk("res_valid", bus.res_valid, 1'b1);
    chk("res_id", bus.res_id, id);
    chk("res_val", bus.res_val, val);
    chk("res_err", bus.res_err, err);
    if (ack) begin
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
    end
  endtask

  initial begin
    int c, seen, len, nf, xi, yi;
    bit xr, yr;
    logic [63:0] fa, fb;

    bus.ld_valid = 0; bus.ld_sel = 0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.job_valid = 0; bus.job_len = '0; bus.job_id = '0;
    bus.arr_x_req = 0; bus.arr_x_idx = '0; bus.arr_y_req = 0; bus.arr_y_idx = '0;
    bus.arr_complete = 0; bus.arr_final = '0; bus.res_ready = 0;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_job_ready", bus.job_ready, 1'b1);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_arr_reset", bus.arr_reset, 1'b1);
    chk("rst_base_vld", bus.arr_base_vld, 1'b0);
    chk("rst_arr_len", bus.arr_len, 7'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_arr_reset", bus.arr_reset, 1'b0);

    // Directed job: len 4, id 5
    ja = '0; ja.id = 4'd5; ja.len = 7'd4;
    for (int i = 0; i < 4; i++) begin ja.x[i] = 2'(i); ja.y[i] = 2'(3 - i); end
    load_commit(ja);
    wait_clear(ja);
    fetch(ja, 1'b0, 1'b1, 0, 2);
    chk("y_idx2_is_1", bus.arr_y_base, 2'd1);
    fetch(ja, 1'b1, 1'b1, 5, 3);
    complete(64'h3FF0000000000000);
    get_result(4'd5, 64'h3FF0000000000000, 1'b0, 1'b1);
    chk("res_drop_after_ack", bus.res_valid, 1'b0);
    bus.arr_x_req = 1'b1;
    tick();
    bus.arr_x_req = 1'b0;
    chk("fetch_ignored_idle", bus.arr_base_vld, 1'b0);

    // Bad lengths skip the array entirely
    for (int k = 0; k < 2; k++) begin
      make_job(jb, 9 + k, (k == 0) ? 0 : MAX_LEN + 1);
      load_commit(jb);
      c = 0; seen = 0;
      while (!bus.res_valid && c < 20) begin
        if (bus.arr_reset) seen = 1;
        tick(); c++;
      end
      chk("badlen_no_clear", seen, 0);
      get_result(jb.id, 64'd0, 1'b1, 1'b1);
    end

    // Watchdog: RUN lasts WDOG cycles, then one DONE cycle publishes
    make_job(jb, 7, 3);
    load_commit(jb);
    wait_clear(jb);
    c = 0;
    while (!bus.res_valid && c < 100) begin tick(); c++; end
    chk("wdog_cycles", c, WDOG + 1);
    get_result(4'd7, 64'd0, 1'b1, 1'b1);

    // Two jobs in flight, results back-pressured
    make_job(ja, 1, 3);
    make_job(jb, 2, 2);
    fa = {$urandom, $urandom};
    fb = {$urandom, $urandom};
    load_commit(ja);
    load_commit(jb);
    chk("both_full_not_ready", bus.job_ready, 1'b0);
    bus.ld_valid = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = 6'd0; bus.ld_data = ~ja.x[0];
    tick();
    bus.ld_valid = 1'b0;
    fetch(ja, 1'b1, 1'b0, 0, 0);
    fetch(ja, 1'b1, 1'b1, 2, 1);
    complete(fa);
    get_result(4'd1, fa, 1'b0, 1'b0);
    wait_clear(jb);
    fetch(jb, 1'b1, 1'b1, 1, 0);
    complete(fb);
    tick(); tick(); tick(); tick();
    chk("hold_valid", bus.res_valid, 1'b1);
    chk("hold_id", bus.res_id, 4'd1);
    chk("hold_val", bus.res_val, fa);
    chk("bank_freed_ready", bus.job_ready, 1'b1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("reload_valid", bus.res_valid, 1'b1);
    get_result(4'd2, fb, 1'b0, 1'b1);
    chk("b_drop_after_ack", bus.res_valid, 1'b0);

    // Randomized jobs; first one exercises full length
    for (int r = 0; r < 6; r++) begin
      len = (r == 0) ? MAX_LEN : int'($urandom_range(1, 12));
      make_job(ja, int'($urandom_range(0, 15)), len);
      load_commit(ja);
      wait_clear(ja);
      if (r == 0) fetch(ja, 1'b1, 1'b1, MAX_LEN - 1, MAX_LEN - 1);
      nf = int'($urandom_range(1, 8));
      for (int f = 0; f < nf; f++) begin
        xr = 1'($urandom_range(0, 1));
        yr = xr ? 1'($urandom_range(0, 1)) : 1'b1;
        xi = int'($urandom_range(0, len + 3)); if (xi > MAX_LEN - 1) xi = MAX_LEN - 1;
        yi = int'($urandom_range(0, len + 3)); if (yi > MAX_LEN - 1) yi = MAX_LEN - 1;
        fetch(ja, xr, yr, xi, yi);
      end
      fa = {$urandom, $urandom};
      complete(fa);
      get_result(ja.id, fa, 1'b0, 1'b1);
    end

    // Reset mid-RUN, then a clean job
    make_job(ja, 3, 4);
    load_commit(ja);
    wait_clear(ja);
    fetch(ja, 1'b1, 1'b0, 1, 0);
    reset = 1'b1;
    tick();
    chk("midrst_job_ready", bus.job_ready, 1'b1);
    chk("midrst_res_valid", bus.res_valid, 1'b0);
    chk("midrst_arr_reset", bus.arr_reset, 1'b1);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.arr_reset) seen = 1;
    end
    chk("midrst_idle", seen, 0);
    make_job(jb, 12, 5);
    fb = {$urandom, $urandom};
    load_commit(jb);
    wait_clear(jb);
    fetch(jb, 1'b1, 1'b1, 4, 2);
    complete(fb);
    get_result(4'd12, fb, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
